// File: rtl/pc_sequencer_if.sv
// Instruction-fetch handshake between the PC sequencer (master) and instruction memory (slave).
// The address follows the PC width; the instruction word is always 32 bits.
interface pc_sequencer_if #(
   parameter int ADDR_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [31:0]       imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/pc_sequencer.sv
// Multicycle PC sequencer: fetches at pc, waits for control-flow resolution, then commits
// the next PC (jr > j > taken branch > pc+4). A misaligned target traps until reset.
module pc_sequencer #(
   parameter int                ADDR_W        = 32,
   parameter logic [ADDR_W-1:0] RESET_PC      = '0,
   parameter logic [31:0]       RETIRED_RESET = 32'h0000_0000
) (
   input  logic              clock,
   input  logic              reset_n,
   pc_sequencer_if.master    imem,
   output logic [31:0]       instr,
   output logic              instr_valid,
   input  logic              resolve_valid,
   input  logic              stall,
   input  logic              isJR,
   input  logic [ADDR_W-1:0] read_data1,
   input  logic              isJ,
   input  logic [ADDR_W-1:0] jumpAddress,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic [31:0]       retired,
   output logic              align_err,
   output logic [1:0]        state
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] FETCH   = 2'd1;
   localparam logic [1:0] RESOLVE = 2'd2;
   localparam logic [1:0] TRAP    = 2'd3;

   logic [ADDR_W-1:0] next_pc;
   logic              commit;
   logic              misaligned;

   assign pc_plus4       = pc + ADDR_W'(4);
   assign imem.imem_req  = (state == FETCH);
   assign imem.imem_addr = pc;

   // Commit only when decode/execute has resolved and nothing is holding the pipeline.
   assign commit     = (state == RESOLVE) && resolve_valid && !stall;
   assign misaligned = |next_pc[1:0];

   always_comb begin
      if (isJR) begin
         next_pc = read_data1;
      end else if (isJ) begin
         next_pc = jumpAddress;
      end else if (branch_taken) begin
         next_pc = branch_target;
      end else begin
         next_pc = pc_plus4;
      end
   end

   // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         instr       <= 32'h0000_0000;
         instr_valid <= 1'b0;
         retired     <= RETIRED_RESET;
         align_err   <= 1'b0;
      end else begin
         instr_valid <= 1'b0;
         case (state)
            IDLE: begin
               state <= FETCH;
            end
            FETCH: begin
               if (imem.imem_ack) begin
                  instr       <= imem.imem_rdata;
                  instr_valid <= 1'b1;
                  state       <= RESOLVE;
               end
            end
            RESOLVE: begin
               if (commit) begin
                  if (misaligned) begin
                     align_err <= 1'b1;
                     state     <= TRAP;
                  end else begin
                     pc      <= next_pc;
                     retired <= retired + 32'd1;
                     state   <= FETCH;
                  end
               end
            end
            default: begin
               state <= TRAP;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a spec-level model checked every cycle, plus literal checkpoints.
module tb_pc_sequencer;

   localparam int         AW        = 32;
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_FETCH   = 2'd1;
   localparam logic [1:0] S_RESOLVE = 2'd2;
   localparam logic [1:0] S_TRAP    = 2'd3;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        resolve_valid = 1'b0;
   logic        stall = 1'b0;
   logic        isJR = 1'b0;
   logic        isJ = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] read_data1 = '0;
   logic [31:0] jumpAddress = '0;
   logic [31:0] branch_target = '0;

   logic [31:0] instr, instr2, pc, pc2, pc_plus4, pc_plus4_2, retired, retired2;
   logic        instr_valid, instr_valid2, align_err, align_err2;
   logic [1:0]  state, state2;

   pc_sequencer_if #(.ADDR_W(AW)) bus ();
   pc_sequencer_if #(.ADDR_W(AW)) bus2 ();
   assign bus2.imem_ack   = bus.imem_ack;
   assign bus2.imem_rdata = bus.imem_rdata;

   pc_sequencer #(.ADDR_W(AW), .RESET_PC(32'h0)) dut (
      .clock(clock), .reset_n(reset_n), .imem(bus.master),
      .instr(instr), .instr_valid(instr_valid),
      .resolve_valid(resolve_valid), .stall(stall),
      .isJR(isJR), .read_data1(read_data1), .isJ(isJ), .jumpAddress(jumpAddress),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .pc(pc), .pc_plus4(pc_plus4), .retired(retired), .align_err(align_err), .state(state)
   );

   // Twin with retired preloaded to all-ones; runs in lockstep to exercise counter wrap.
   pc_sequencer #(.ADDR_W(AW), .RESET_PC(32'h0), .RETIRED_RESET(32'hFFFF_FFFF)) dut_wrap (
      .clock(clock), .reset_n(reset_n), .imem(bus2.master),
      .instr(instr2), .instr_valid(instr_valid2),
      .resolve_valid(resolve_valid), .stall(stall),
      .isJR(isJR), .read_data1(read_data1), .isJ(isJ), .jumpAddress(jumpAddress),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .pc(pc2), .pc_plus4(pc_plus4_2), .retired(retired2), .align_err(align_err2), .state(state2)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, actual, expected, $time);
      end
   endtask

   // Behavioural model: phase 0 idle, 1 fetching, 2 awaiting resolution, 3 trapped.
   int          m_phase = 0;
   logic [31:0] m_pc = '0;
   logic [31:0] m_instr = '0;
   logic [31:0] m_retired = '0;
   logic [31:0] m_target = '0;
   bit          m_valid = 1'b0;
   bit          m_err = 1'b0;
   bit          model_ready = 1'b0;

   always @(posedge clock) begin
      if (!reset_n) begin
         m_phase = 0; m_pc = '0; m_instr = '0; m_retired = '0;
         m_valid = 1'b0; m_err = 1'b0; model_ready = 1'b1;
      end else begin
         m_valid = 1'b0;
         if (m_phase == 0) begin
            m_phase = 1;
         end else if (m_phase == 1) begin
            if (bus.imem_ack) begin
               m_instr = bus.imem_rdata;
               m_valid = 1'b1;
               m_phase = 2;
            end
         end else if (m_phase == 2 && resolve_valid && !stall) begin
            m_target = isJR ? read_data1 : isJ ? jumpAddress :
                       branch_taken ? branch_target : m_pc + 32'd4;
            if (m_target % 4 != 0) begin
               m_err   = 1'b1;
               m_phase = 3;
            end else begin
               m_pc      = m_target;
               m_retired = m_retired + 32'd1;
               m_phase   = 1;
            end
         end
      end
   end

   int n_fetch_cycles = 0;
   int n_valid = 0;

   always @(negedge clock) begin
      if (model_ready) begin
         check("state", 32'(state), 32'(m_phase));
         check("imem_req", 32'(bus.imem_req), 32'(m_phase == 1));
         check("imem_addr", bus.imem_addr, m_pc);
         check("pc", pc, m_pc);
         check("pc_plus4", pc_plus4, m_pc + 32'd4);
         check("instr", instr, m_instr);
         check("instr_valid", 32'(instr_valid), 32'(m_valid));
         check("retired", retired, m_retired);
         check("align_err", 32'(align_err), 32'(m_err));
         check("retired_wrap_twin", retired2, m_retired + 32'hFFFF_FFFF);
         if (bus.imem_req) n_fetch_cycles++;
         if (instr_valid) n_valid++;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_state(input logic [1:0] s);
      int n = 0;
      while (state !== s && n < 50) begin
         tick();
         n++;
      end
      if (state !== s) check("wait_state_timeout", 32'(state), 32'(s));
   endtask

   task automatic fetch(input logic [31:0] word, input int waits);
      wait_state(S_FETCH);
      bus.imem_rdata = word;
      bus.imem_ack   = 1'b0;
      repeat (waits) tick();
      bus.imem_ack = 1'b1;
      tick();
      bus.imem_ack = 1'b0;
   endtask

   task automatic resolve(input logic jr, input logic [31:0] rd1, input logic j,
                          input logic [31:0] ja, input logic bt, input logic [31:0] btg);
      wait_state(S_RESOLVE);
      isJR = jr; read_data1 = rd1; isJ = j; jumpAddress = ja;
      branch_taken = bt; branch_target = btg;
      resolve_valid = 1'b1; stall = 1'b0;
      tick();
      resolve_valid = 1'b0; isJR = 1'b0; isJ = 1'b0; branch_taken = 1'b0;
   endtask

   int f0, v0;

   initial begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = '0;
      reset_n = 1'b0;
      repeat (2) tick();
      check("reset_state", 32'(state), 32'(S_IDLE));
      check("reset_pc", pc, 32'h0);
      check("reset_retired", retired, 32'h0);
      check("reset_retired_twin", retired2, 32'hFFFF_FFFF);
      check("reset_imem_req", 32'(bus.imem_req), 32'h0);
      reset_n = 1'b1;

      // Two-wait-state fetch, plain sequential resolve.
      f0 = n_fetch_cycles; v0 = n_valid;
      fetch(32'h2008_0005, 2);
      check("t1_instr", instr, 32'h2008_0005);
      resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      check("t1_pc", pc, 32'h0000_0004);
      check("t1_retired", retired, 32'd1);
      check("t1_retired_twin_wrapped", retired2, 32'h0);
      check("t1_fetch_cycles", 32'(n_fetch_cycles - f0), 32'd3);
      check("t1_valid_pulses", 32'(n_valid - v0), 32'd1);

      // jr outranks j.
      fetch(32'h03E0_0008, 0);
      resolve(1'b1, 32'h0040_0010, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
      check("t2_pc_jr_priority", pc, 32'h0040_0010);
      check("t2_retired", retired, 32'd2);

      // Taken branch held by stall for three cycles.
      fetch(32'h1000_0007, 0);
      wait_state(S_RESOLVE);
      branch_taken = 1'b1; branch_target = 32'h20; resolve_valid = 1'b1; stall = 1'b1;
      repeat (3) begin
         tick();
         check("t3_pc_held", pc, 32'h0040_0010);
         check("t3_retired_held", retired, 32'd2);
      end
      stall = 1'b0;
      tick();
      resolve_valid = 1'b0; branch_taken = 1'b0;
      check("t3_pc_branch", pc, 32'h0000_0020);
      check("t3_retired", retired, 32'd3);

      // Jump to top of address space, then pc+4 wraps to a legal zero.
      fetch(32'h0800_0000, 0);
      resolve(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
      check("t5_pc_top", pc, 32'hFFFF_FFFC);
      check("t5_pc_plus4_wrap", pc_plus4, 32'h0);
      fetch(32'h0000_0000, 1);
      resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      check("t5_pc_wrapped", pc, 32'h0);
      check("t5_no_align_err", 32'(align_err), 32'h0);
      check("t5_state_fetch", 32'(state), 32'(S_FETCH));
      check("t5_retired", retired, 32'd5);

      // Reset mid-FETCH with an ack on the same edge.
      wait_state(S_FETCH);
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF; reset_n = 1'b0;
      tick();
      check("t6_state", 32'(state), 32'(S_IDLE));
      check("t6_pc", pc, 32'h0);
      check("t6_instr", instr, 32'h0);
      check("t6_instr_valid", 32'(instr_valid), 32'h0);
      check("t6_retired", retired, 32'h0);
      bus.imem_ack = 1'b0; reset_n = 1'b1;

      // Misaligned jr target traps; nothing moves afterwards.
      fetch(32'h00C0_0008, 1);
      resolve(1'b1, 32'h0000_0006, 1'b0, 32'h0, 1'b0, 32'h0);
      check("t4_state_trap", 32'(state), 32'(S_TRAP));
      check("t4_align_err", 32'(align_err), 32'h1);
      check("t4_pc_unchanged", pc, 32'h0);
      check("t4_retired_unchanged", retired, 32'h0);
      repeat (10) begin
         bus.imem_ack = 1'b1; resolve_valid = 1'b1; isJ = 1'b1; jumpAddress = 32'h40;
         tick();
         check("t4_imem_req_low", 32'(bus.imem_req), 32'h0);
         check("t4_still_trap", 32'(state), 32'(S_TRAP));
         check("t4_pc_frozen", pc, 32'h0);
      end
      bus.imem_ack = 1'b0; resolve_valid = 1'b0; isJ = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multicycle program-counter sequencer for the MIPS core. It owns the PC register and issues instruction fetches to instruction memory with a req/ack handshake. It waits for decode/execute to resolve the control flow, then commits the next PC. Next-PC priority is jr register target, then jump target, then taken branch, then PC+4.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
ADDR_W, 32, width of the PC and all address/target buses.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset_n  input  1  synchronous, active-low reset.
imem_req  output  1  fetch request; high exactly while state==FETCH.
imem_addr  output  ADDR_W  fetch address; equals pc.
imem_ack  input  1  memory returns data this cycle; sampled only in FETCH.
imem_rdata  input  32  instruction word; valid when imem_ack=1.
instr  output  32  latched instruction word.
instr_valid  output  1  one-cycle pulse, first cycle of RESOLVE.
resolve_valid  input  1  control-flow inputs below are valid this cycle.
stall  input  1  holds RESOLVE even if resolve_valid=1.
isJR  input  1  jr: next PC = read_data1.
read_data1  input  ADDR_W  register rs value for jr.
isJ  input  1  j/jal: next PC = jumpAddress.
jumpAddress  input  ADDR_W  precomputed jump target.
branch_taken  input  1  next PC = branch_target.
branch_target  input  ADDR_W  precomputed branch target.
pc  output  ADDR_W  current PC register.
pc_plus4  output  ADDR_W  pc+4, combinational, modulo 2^ADDR_W.
retired  output  32  committed-instruction counter.
align_err  output  1  sticky: a committed target had bits[1:0]!=0.
state  output  2  IDLE=0, FETCH=1, RESOLVE=2, TRAP=3.

Behaviour:
- Reset (reset_n=0 at a clock edge) gives: pc=RESET_PC, state=IDLE, instr=0, instr_valid=0, retired=0, align_err=0, imem_req=0. Reset wins over every other event and aborts any in-flight fetch or resolve.
- IDLE: always goes to FETCH on the next cycle.
- FETCH: imem_req=1 and imem_addr=pc. If imem_ack=0, stay in FETCH. If imem_ack=1: instr<=imem_rdata, instr_valid<=1, go to RESOLVE. An ack in the same cycle FETCH is entered is accepted, giving 1-cycle minimum fetch latency.
- imem_ack outside FETCH is ignored.
- RESOLVE: instr_valid is high only in the first cycle. Stay in RESOLVE while resolve_valid=0 or stall=1.
- On resolve_valid=1 and stall=0, select next PC by priority: isJR ? read_data1 : isJ ? jumpAddress : branch_taken ? branch_target : pc_plus4.
- If the selected next PC has bits[1:0]==0: pc<=next, retired<=retired+1 (wraps at 2^32-1 to 0), go to FETCH.
- If bits[1:0]!=0: pc is unchanged, retired is unchanged, align_err<=1, go to TRAP.
- Simultaneous select flags: the highest priority wins silently. Control inputs are don't-care outside RESOLVE.
- TRAP: absorbing state with imem_req=0. Only reset exits it.
- PC+4 wrap: 32'hFFFF_FFFC+4 = 32'h0000_0000, which is a legal target.
- Best-case throughput is one instruction per 2 cycles: FETCH with ack, then RESOLVE with resolve_valid.

Test Plan:
1. Reset with RESET_PC=0; ack after 2 wait cycles; resolve with no flags -> imem_addr=0 held 3 cycles, instr_valid pulses once, pc=4, retired=1.
2. In RESOLVE, isJR=1 with read_data1=0x0040_0010, and isJ=1 with jumpAddress=0x0000_0100 -> pc=0x0040_0010 (JR priority).
3. In RESOLVE, branch_taken=1, branch_target=0x20, stall=1 for 3 cycles then 0 -> pc updates only on the cycle after stall drops; retired increments exactly once.
4. isJR=1 with read_data1=0x0000_0006 -> state=TRAP, align_err=1, pc unchanged, imem_req stays 0 for 10 cycles.
5. pc=0xFFFF_FFFC, resolve with no flags -> pc=0x0000_0000, no error. Separately, preload retired=0xFFFF_FFFF and commit -> retired=0.
6. Assert reset_n=0 mid-FETCH with imem_ack=1 on the same edge -> state=IDLE, pc=RESET_PC, instr=0, instr_valid=0.
